// File: rtl/multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundles the signals between the multi-cycle control sequencer and the
// RV32I datapath/memory.
//
// Handshake: the sequencer holds mem_read or mem_write high until the cycle
// in which memory returns mem_ready=1 (that cycle included). mem_ready is
// only looked at in FETCH, MEM_RD and MEM_WR. The two strobes are never high
// together.
//
// Signals
//   opcode, funct3 : instruction fields from the instruction register
//   zero           : ALU zero flag
//   mem_ready      : memory completes the current access this cycle
//   alu_src        : 0 = reg_out2, 1 = immediate
//   alu_op         : 00 add, 01 subtract, 10 decode from funct fields
//   pc_write       : load PC this cycle
//   pc_src         : 0 = PC+4, 1 = branch/jump target
//   ir_write       : latch the fetched instruction
//   mem_read       : memory read strobe
//   mem_write      : memory write strobe
//   reg_write      : register-file write enable
//   wb_sel         : 00 ALU, 01 memory, 10 PC+4
//   illegal        : trap flag
// Modports
//   master : the sequencer (drives the control signals)
//   slave  : the datapath side (drives instruction fields and status)
// ----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output alu_src, alu_op, pc_write, pc_src, ir_write,
               mem_read, mem_write, reg_write, wb_sel, illegal
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  alu_src, alu_op, pc_write, pc_src, ir_write,
               mem_read, mem_write, reg_write, wb_sel, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control sequencer for the RV32I core. Walks each instruction
// through FETCH, DECODE, EXEC/ADDR/BRANCH/JAL, memory and write-back states
// and drives the datapath controls as Moore decodes of the state (with
// mem_ready / zero qualification where noted).
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset; forces every control output to 0
//             while low
//   bus     : multicycle_ctrl_if.master, control and handshake signals
//   state   : current state (debug)
//   retired : count of completed instructions, wraps modulo 2^CNT_W
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : unknown opcodes park in TRAP (illegal=1) until reset
//   undefined : unknown opcodes are retired as NOPs, illegal tied to 0
// ----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_ctrl_if.master bus,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC    = 4'd2,
        S_ALU_WB  = 4'd3,
        S_ADDR    = 4'd4,
        S_MEM_RD  = 4'd5,
        S_LOAD_WB = 4'd6,
        S_MEM_WR  = 4'd7,
        S_BRANCH  = 4'd8,
        S_JAL     = 4'd9,
        S_TRAP    = 4'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t cur_state;
    state_t nxt_state;
    logic   retire;

    logic       alu_src;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            retired   <= '0;
        end else begin
            cur_state <= nxt_state;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        retire    = 1'b0;
        alu_src   = 1'b0;
        alu_op    = 2'b00;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        illegal   = 1'b0;

        case (cur_state)
            S_FETCH: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_R, OP_I:        nxt_state = S_EXEC;
                    OP_LOAD, OP_STORE: nxt_state = S_ADDR;
                    OP_BRANCH:         nxt_state = S_BRANCH;
                    OP_JAL:            nxt_state = S_JAL;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        nxt_state = S_TRAP;
`else
                        // PC already advanced in FETCH, so this is a NOP.
                        nxt_state = S_FETCH;
                        retire    = 1'b1;
`endif
                    end
                endcase
            end
            S_EXEC: begin
                alu_op    = 2'b10;
                alu_src   = (bus.opcode == OP_I);
                nxt_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                // Keep the operand mux stable while the result is written.
                alu_src   = (bus.opcode == OP_I);
                reg_write = 1'b1;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_ADDR: begin
                alu_src   = 1'b1;
                nxt_state = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                alu_src  = 1'b1;
                if (bus.mem_ready) begin
                    nxt_state = S_LOAD_WB;
                end
            end
            S_LOAD_WB: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                if (bus.mem_ready) begin
                    nxt_state = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_BRANCH: begin
                alu_op = 2'b01;
                pc_src = 1'b1;
                case (bus.funct3)
                    3'b000:  pc_write = bus.zero;
                    3'b001:  pc_write = !bus.zero;
                    default: pc_write = 1'b0;
                endcase
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                pc_src    = 1'b1;
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal   = 1'b1;
                nxt_state = S_TRAP;
            end
`endif
            default: begin
                nxt_state = S_FETCH;
            end
        endcase
    end

    // Reset overrides every output combinationally, so nothing is strobed
    // even before the first reset edge has been seen.
    assign bus.alu_src   = rst_n & alu_src;
    assign bus.alu_op    = rst_n ? alu_op : 2'b00;
    assign bus.pc_write  = rst_n & pc_write;
    assign bus.pc_src    = rst_n & pc_src;
    assign bus.ir_write  = rst_n & ir_write;
    assign bus.mem_read  = rst_n & mem_read;
    assign bus.mem_write = rst_n & mem_write;
    assign bus.reg_write = rst_n & reg_write;
    assign bus.wb_sel    = rst_n ? wb_sel : 2'b00;
    assign bus.illegal   = rst_n & illegal;

    assign state = cur_state;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32I core. Walks each instruction through fetch, decode, execute, memory and write-back states. Drives the `alu_src` operand mux select, register-file write enable, memory strobes, PC update and ALU operation class. Sits between the instruction register and the datapath, replacing the single-cycle combinational decoder so that memory and the ALU can be shared across cycles.

## Interface

**Parameters**
- `CNT_W`, default 32: width of the retired-instruction counter.

**Ports**
- `clk` — in, 1: system clock, rising edge.
- `rst_n` — in, 1: reset, synchronous, active-low.
- `opcode` — in, 7: `ir[6:0]`. Valid from DECODE onward.
- `funct3` — in, 3: `ir[14:12]`.
- `zero` — in, 1: ALU zero flag.
- `mem_ready` — in, 1: memory completes the current read or write this cycle.
- `alu_src` — out, 1: 0 selects `reg_out2`, 1 selects the immediate.
- `alu_op` — out, 2: 00 add (address), 01 subtract (branch), 10 decode from funct fields.
- `pc_write` — out, 1: load PC this cycle.
- `pc_src` — out, 1: 0 selects PC+4, 1 selects branch/jump target.
- `ir_write` — out, 1: latch instruction from memory.
- `mem_read` — out, 1: memory read strobe.
- `mem_write` — out, 1: memory write strobe.
- `reg_write` — out, 1: register-file write enable.
- `wb_sel` — out, 2: 00 ALU, 01 memory, 10 PC+4.
- `illegal` — out, 1: trap flag.
- `state` — out, 4: current state, for debug.
- `retired` — out, `CNT_W`: count of completed instructions.

## Operation

**State encoding**
- FETCH=0, DECODE=1, EXEC=2, ALU_WB=3, ADDR=4, MEM_RD=5, LOAD_WB=6, MEM_WR=7, BRANCH=8, JAL=9, TRAP=10.
- Outputs are Moore decodes of `state`, except the outputs qualified by `mem_ready`/`zero` below.
- Any output not listed for a state is 0.

**Per-state outputs and transitions**
- **FETCH**
  - `mem_read`=1.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, next state DECODE.
  - Otherwise remain in FETCH.
- **DECODE** — no outputs. Next state by opcode:
  - 0110011 or 0010011 → EXEC.
  - 0000011 or 0100011 → ADDR.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - Any other opcode → illegal handling (see Configuration).
- **EXEC**
  - `alu_op`=10.
  - `alu_src`=1 if opcode is 0010011, else 0.
  - Next state ALU_WB.
- **ALU_WB**
  - `reg_write`=1, `wb_sel`=00, `alu_src` held as in EXEC.
  - Next state FETCH.
- **ADDR**
  - `alu_src`=1, `alu_op`=00.
  - Opcode 0000011 → MEM_RD; opcode 0100011 → MEM_WR.
- **MEM_RD**
  - `mem_read`=1, `alu_src`=1.
  - Wait for `mem_ready`, then LOAD_WB.
- **LOAD_WB**
  - `reg_write`=1, `wb_sel`=01.
  - Next state FETCH.
- **MEM_WR**
  - `mem_write`=1, `alu_src`=1.
  - Wait for `mem_ready`, then FETCH.
- **BRANCH**
  - `alu_src`=0, `alu_op`=01, `pc_src`=1.
  - `pc_write` = `zero` when funct3=000, `!zero` when funct3=001, 0 for other funct3.
  - Next state FETCH.
- **JAL**
  - `pc_write`=1, `pc_src`=1, `reg_write`=1, `wb_sel`=10.
  - Next state FETCH.

**Retired counter**
- Increments by 1 on every transition into FETCH from ALU_WB, LOAD_WB, MEM_WR, BRANCH or JAL.
- Wraps modulo 2^`CNT_W` with no saturation.

## Timing

**Reset**
- On a rising edge with `rst_n`=0: `state`=FETCH, `retired`=0, `illegal`=0.
- While `rst_n` is low, all control outputs are forced to 0, including FETCH's `mem_read`.
- The first `mem_read` is asserted in the first cycle with `rst_n`=1.
- Reset in any state, including MEM_RD/MEM_WR mid-wait, aborts the access. The next state is FETCH and no write-back occurs.

**Latency with zero-wait memory** (FETCH counted as 1 cycle)
- R/I ALU: 4 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
- Branch: 3 cycles.
- JAL: 3 cycles.
- Each memory wait cycle adds 1.

**Handshake**
- `mem_read`/`mem_write` stay high until the cycle in which `mem_ready`=1, inclusive.
- `mem_ready` is ignored in all states other than FETCH, MEM_RD and MEM_WR.
- Strobes never overlap: `mem_read` and `mem_write` are never both high.

## Configuration

`ILLEGAL_TRAP_EN`
- **Defined:** an unrecognised opcode in DECODE moves to TRAP.
  - TRAP asserts `illegal`=1 and holds all other outputs at 0.
  - TRAP remains until reset. `retired` does not increment.
- **Undefined:** an unrecognised opcode in DECODE returns directly to FETCH and is treated as a NOP.
  - PC was already advanced in FETCH.
  - `retired` increments on that transition.
  - `illegal` is tied to 0 and TRAP is unreachable.

## Test plan

- **Reset held 3 cycles, then released, `mem_ready`=1:** all outputs 0 during reset, `mem_read`=1 in the first post-reset cycle, `state`=0, `retired`=0.
- **R-type (opcode 0110011), zero-wait memory:** sequence FETCH→DECODE→EXEC→ALU_WB→FETCH in 4 cycles; `alu_src`=0; `reg_write`=1 for exactly 1 cycle; `retired`=1.
- **Load (opcode 0000011), `mem_ready` low for 2 cycles in MEM_RD:** `mem_read` high for 3 cycles in MEM_RD, `alu_src`=1, `wb_sel`=01 in LOAD_WB, total 7 cycles.
- **BEQ (funct3=000):** with `zero`=1, `pc_write`=1 and `pc_src`=1 in BRANCH; with `zero`=0, `pc_write`=0; BNE gives the inverse.
- **Opcode 0000000:**
  - With `ILLEGAL_TRAP_EN` defined: `state`=10 and `illegal`=1, held for 20 cycles.
  - Without it: back in FETCH after DECODE, with `retired` incremented.
- **Reset asserted while in MEM_WR waiting:** next cycle `state`=FETCH, `mem_write`=0, `retired` unchanged from 0 after reset.
